i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
- I2C responder at the far end of the design's I2C master link; stands in for the motion sensor on hardware-in-loop and loopback benches.
- Decodes START, STOP, the device address, a register pointer and data bytes from SCL/SDA.
- Maps I2C writes and reads onto a simple byte register-file port, so any sensor model (register file, test pattern ROM) can answer the flight controller's init writes and 14-byte burst reads.

Parameters:
- DEVICE_ADDR, 7'b1101000: 7-bit address this slave answers to.
- SYNC_STAGES, 2: synchroniser depth on SCL and SDA_IN (minimum 2).

Ports:
- CLK  in  1  system clock; must be at least 16x the SCL rate.
- RST  in  1  synchronous, active-high reset.
- SCL  in  1  I2C clock from the master, asynchronous.
- SDA_IN  in  1  I2C data from the pad, asynchronous.
- SDA_OUT  out  1  data driven when SDA_DIR=1; always 0 (open-drain pull-low).
- SDA_DIR  out  1  1 = slave pulls SDA low, 0 = released.
- REG_ADDR  out  8  current register pointer.
- WRITE_EN  out  1  one-CLK pulse; write WRITE_DATA at REG_ADDR.
- WRITE_DATA  out  8  byte received from the master.
- READ_EN  out  1  one-CLK pulse; request the byte at REG_ADDR.
- READ_DATA  in  8  register byte, valid the CLK cycle after READ_EN.
- BUSY  out  1  1 while this slave is addressed (address ACK until STOP, repeated START or NACKed read).
- NACK_SEEN  out  1  one-CLK pulse when the master NACKs a read byte.

Behaviour:
- Reset: SDA_DIR=0, SDA_OUT=0, REG_ADDR=0, WRITE_EN=0, WRITE_DATA=0, READ_EN=0, BUSY=0, NACK_SEEN=0; state IDLE.
- Input conditioning: SCL and SDA_IN each pass through SYNC_STAGES flops. Edges are detected on the synchronised values; all decisions use synchronised signals only.
- START: SDA falling while SCL high. Valid in any state, including mid-byte; it is a repeated start when already active. Goes to ADDR with bit count cleared; SDA released.
- STOP: SDA rising while SCL high. Valid in any state; goes to IDLE, BUSY=0, SDA released.
- Sampling: SDA is sampled on the SCL rising edge. The slave changes SDA only on the first CLK after an SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first (7 address bits plus R/W). On a match go to ACK_A; on a mismatch go to IGNORE (never drive SDA until the next START or STOP).
  - ACK_A: pull SDA low for one SCL period; BUSY=1.
    - Write (R/W=0): go to PTR.
    - Read (R/W=1): pulse READ_EN during ACK_A, latch READ_DATA into the shift register, go to RD.
  - PTR: shift in 8 bits, load REG_ADDR, go to ACK_P (drive ACK), then WR.
  - WR: shift in 8 bits. After the 8th bit, set WRITE_DATA and pulse WRITE_EN at the current REG_ADDR in the same CLK. Go to ACK_W (drive ACK). REG_ADDR increments on the SCL falling edge that ends ACK_W.
  - RD: drive bits MSB first. A '0' bit pulls SDA low; a '1' bit releases it. After 8 bits, release SDA and go to MACK.
  - MACK: sample the master's ACK on the SCL rising edge.
    - ACK: REG_ADDR+1, pulse READ_EN, latch the next byte, return to RD on the SCL falling edge.
    - NACK: pulse NACK_SEEN, BUSY=0, go to IGNORE.
- Pointer: 8-bit, wraps 255 to 0; it is not reset by START or STOP.
- A write transaction whose first data byte was never sent (pointer only) changes only REG_ADDR.
- Repeated START then read: the read starts at the pointer set by the preceding write. This is the standard register-read pattern used by the sensor driver.
- Truncation: a START or STOP mid-byte discards the partial byte, with no WRITE_EN.
- Reset mid-transaction: SDA is released in the same cycle as RST; the slave must see a new START before it responds again.
- No clock stretching. READ_DATA latency must stay at 1 CLK; the byte is latched at least 4 CLK before the SCL falling edge that drives the first bit.

Decomposition:
- Shared package:
  - State enum (IDLE, ADDR, ACK_A, PTR, ACK_P, WR, ACK_W, RD, MACK, IGNORE).
  - Bit-count width constant.
  - Default sensor address constant 7'b1101000, shared with the top level's master instance.
- Sub-module: i2c_line_sync. It holds the synchroniser plus edge/START/STOP detection and outputs scl_rise, scl_fall, start, stop and sda_s.
- The FSM, shifter and pointer live in i2c_slave_regs.

Test Plan:
- Write 0x68+W, 0x6B, 0x00, STOP -> ACK on all 3 bytes; one WRITE_EN with REG_ADDR=0x6B, WRITE_DATA=0x00; BUSY falls at STOP.
- Write 0x68+W, 0x3B, repeated START, 0x68+R, read 14 bytes (ACK 13, NACK last), with a model returning data = addr -> bytes 0x3B..0x48; 14 READ_EN pulses; one NACK_SEEN; REG_ADDR=0x49.
- Address 0x69+W -> SDA_DIR stays 0 for the whole transaction; no WRITE_EN; BUSY=0.
- Pointer 0xFF, write 0xAA, 0xBB -> WRITE_EN at 0xFF then 0x00 (wrap).
- STOP after 4 bits of a data byte -> no WRITE_EN, state IDLE; the next full write works.
- RST asserted while driving a read '0' bit -> SDA_DIR=0 the next CLK; all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave_regs_pkg.sv
// Shared types and constants for the I2C register slave.
// Also carries the sensor address used by the master side.
package i2c_slave_regs_pkg;

  localparam int CNT_W = 4;

  localparam logic [6:0] SENSOR_ADDR = 7'b1101000;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_A,
    PTR,
    ACK_P,
    WR,
    ACK_W,
    RD,
    MACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA and detects edges, START and STOP.
// All outputs are derived from synchronised samples only.
module i2c_line_sync
  import i2c_slave_regs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic                   scl_p;
  logic                   sda_p;
  logic                   scl_s;

  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_s = sda_q[SYNC_STAGES-1];

  // Shift the lines in; idle bus is high, so reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start    = scl_s & scl_p & sda_p & ~sda_s;
  assign stop     = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave mapping writes/reads onto a byte register port.
// Pointer auto-increments; reads prefetch one byte ahead.
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = SENSOR_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL,
  input  logic       SDA_IN,
  output logic       SDA_OUT,
  output logic       SDA_DIR,
  output logic [7:0] REG_ADDR,
  output logic       WRITE_EN,
  output logic [7:0] WRITE_DATA,
  output logic       READ_EN,
  input  logic [7:0] READ_DATA,
  output logic       BUSY,
  output logic       NACK_SEEN
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(8);

  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;
  logic sda_s;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (CLK),
    .rst     (RST),
    .scl     (SCL),
    .sda     (SDA_IN),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop),
    .sda_s   (sda_s)
  );

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       byte_in;
  logic             rw, rw_n;
  logic             ack_on, ack_on_n;
  logic             mack_ok, mack_ok_n;
  logic             rd_pend, rd_pend_n;
  logic             sda_dir, sda_dir_n;
  logic [7:0]       reg_addr, reg_addr_n;
  logic             write_en, write_en_n;
  logic [7:0]       write_data, write_data_n;
  logic             read_en, read_en_n;
  logic             busy, busy_n;
  logic             nack, nack_n;

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      rw         <= 1'b0;
      ack_on     <= 1'b0;
      mack_ok    <= 1'b0;
      rd_pend    <= 1'b0;
      sda_dir    <= 1'b0;
      reg_addr   <= '0;
      write_en   <= 1'b0;
      write_data <= '0;
      read_en    <= 1'b0;
      busy       <= 1'b0;
      nack       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shift      <= shift_n;
      rw         <= rw_n;
      ack_on     <= ack_on_n;
      mack_ok    <= mack_ok_n;
      rd_pend    <= rd_pend_n;
      sda_dir    <= sda_dir_n;
      reg_addr   <= reg_addr_n;
      write_en   <= write_en_n;
      write_data <= write_data_n;
      read_en    <= read_en_n;
      busy       <= busy_n;
      nack       <= nack_n;
    end
  end

  // Next-state, shifter, pointer and strobes.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shift_n      = shift;
    rw_n         = rw;
    ack_on_n     = ack_on;
    mack_ok_n    = mack_ok;
    rd_pend_n    = read_en;
    sda_dir_n    = sda_dir;
    reg_addr_n   = reg_addr;
    write_en_n   = 1'b0;
    write_data_n = write_data;
    read_en_n    = 1'b0;
    busy_n       = busy;
    nack_n       = 1'b0;
    byte_in      = {shift[6:0], sda_s};

    // READ_DATA is valid the cycle after READ_EN.
    if (rd_pend) shift_n = READ_DATA;

    if (start) begin
      state_n   = ADDR;
      cnt_n     = '0;
      sda_dir_n = 1'b0;
      busy_n    = 1'b0;
      ack_on_n  = 1'b0;
      mack_ok_n = 1'b0;
    end else if (stop) begin
      state_n   = IDLE;
      sda_dir_n = 1'b0;
      busy_n    = 1'b0;
      ack_on_n  = 1'b0;
      mack_ok_n = 1'b0;
    end else begin
      unique case (state)
        ADDR, PTR, WR: begin
          if (scl_rise) begin
            shift_n = byte_in;
            cnt_n   = cnt + 1'b1;
            if (cnt == LAST) begin
              cnt_n    = '0;
              ack_on_n = 1'b0;
              if (state == ADDR) begin
                if (byte_in[7:1] == DEVICE_ADDR) begin
                  state_n = ACK_A;
                  rw_n    = byte_in[0];
                  busy_n  = 1'b1;
                end else begin
                  state_n = IGNORE;
                end
              end else if (state == PTR) begin
                reg_addr_n = byte_in;
                state_n    = ACK_P;
              end else begin
                write_data_n = byte_in;
                write_en_n   = 1'b1;
                state_n      = ACK_W;
              end
            end
          end
        end
        ACK_A, ACK_P, ACK_W: begin
          if (scl_fall) begin
            if (!ack_on) begin
              ack_on_n  = 1'b1;
              sda_dir_n = 1'b1;
              if (state == ACK_A && rw) read_en_n = 1'b1;
            end else begin
              ack_on_n  = 1'b0;
              cnt_n     = '0;
              sda_dir_n = 1'b0;
              if (state == ACK_A && rw) begin
                state_n   = RD;
                sda_dir_n = ~shift[7];
              end else if (state == ACK_A) begin
                state_n = PTR;
              end else if (state == ACK_P) begin
                state_n = WR;
              end else begin
                state_n    = WR;
                reg_addr_n = reg_addr + 1'b1;
              end
            end
          end
        end
        RD: begin
          if (scl_rise) begin
            cnt_n = cnt + 1'b1;
          end else if (scl_fall) begin
            if (cnt == FULL) begin
              sda_dir_n = 1'b0;
              state_n   = MACK;
              cnt_n     = '0;
              mack_ok_n = 1'b0;
            end else begin
              shift_n   = {shift[6:0], 1'b0};
              sda_dir_n = ~shift[6];
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            reg_addr_n = reg_addr + 1'b1;
            if (!sda_s) begin
              read_en_n = 1'b1;
              mack_ok_n = 1'b1;
            end else begin
              nack_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = IGNORE;
            end
          end else if (scl_fall && mack_ok) begin
            state_n   = RD;
            sda_dir_n = ~shift[7];
            mack_ok_n = 1'b0;
            cnt_n     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA_OUT    = 1'b0;
  assign SDA_DIR    = sda_dir & ~RST;
  assign REG_ADDR   = reg_addr;
  assign WRITE_EN   = write_en;
  assign WRITE_DATA = write_data;
  assign READ_EN    = read_en;
  assign BUSY       = busy;
  assign NACK_SEEN  = nack;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: bit-banged I2C master plus a register model
// whose READ_DATA equals the requested address.
module tb_i2c_slave_regs;
  import i2c_slave_regs_pkg::*;

  localparam int Q = 80;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SCL = 1'b1;
  logic       sda_m = 1'b1;
  logic       SDA_IN;
  logic       SDA_OUT;
  logic       SDA_DIR;
  logic [7:0] REG_ADDR;
  logic       WRITE_EN;
  logic [7:0] WRITE_DATA;
  logic       READ_EN;
  logic [7:0] READ_DATA = 8'h00;
  logic       BUSY;
  logic       NACK_SEEN;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int nack_cnt = 0;
  int dir_cnt = 0;
  logic [7:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];

  assign SDA_IN = sda_m & ~SDA_DIR;

  always #5 CLK = ~CLK;

  i2c_slave_regs dut (
    .CLK       (CLK),
    .RST       (RST),
    .SCL       (SCL),
    .SDA_IN    (SDA_IN),
    .SDA_OUT   (SDA_OUT),
    .SDA_DIR   (SDA_DIR),
    .REG_ADDR  (REG_ADDR),
    .WRITE_EN  (WRITE_EN),
    .WRITE_DATA(WRITE_DATA),
    .READ_EN   (READ_EN),
    .READ_DATA (READ_DATA),
    .BUSY      (BUSY),
    .NACK_SEEN (NACK_SEEN)
  );

  // Register model and event logging.
  always @(posedge CLK) begin
    if (READ_EN) begin
      READ_DATA <= REG_ADDR;
      rd_cnt    <= rd_cnt + 1;
    end
    if (WRITE_EN) begin
      wr_addr_log[wr_cnt[5:0]] <= REG_ADDR;
      wr_data_log[wr_cnt[5:0]] <= WRITE_DATA;
      wr_cnt <= wr_cnt + 1;
    end
    if (NACK_SEEN) nack_cnt <= nack_cnt + 1;
    if (SDA_DIR) dir_cnt <= dir_cnt + 1;
  end

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sbit(input logic b, output logic s);
    sda_m = b;
    #Q SCL = 1'b1;
    #Q s = SDA_IN;
    #Q SCL = 1'b0;
    #Q;
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    #Q SCL = 1'b1;
    #Q sda_m = 1'b0;
    #Q SCL = 1'b0;
    #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    #Q SCL = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) sbit(b[i], s);
    sbit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sbit(1'b1, s);
      d[i] = s;
    end
    sbit(~ack, s);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         w0, r0, n0, d0;

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk1("rst_dir", SDA_DIR, 1'b0);
    chk1("rst_out", SDA_OUT, 1'b0);
    chk8("rst_addr", REG_ADDR, 8'h00);
    chk1("rst_wen", WRITE_EN, 1'b0);
    chk8("rst_wdata", WRITE_DATA, 8'h00);
    chk1("rst_ren", READ_EN, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_nack", NACK_SEEN, 1'b0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // single register write
    w0 = wr_cnt;
    start_c();
    wbyte(8'hD0, a); chk1("w1_ack_addr", a, 1'b1);
    chk1("w1_busy", BUSY, 1'b1);
    wbyte(8'h6B, a); chk1("w1_ack_ptr", a, 1'b1);
    wbyte(8'h00, a); chk1("w1_ack_data", a, 1'b1);
    chk1("w1_busy_pre_stop", BUSY, 1'b1);
    stop_c();
    chki("w1_wr_count", wr_cnt - w0, 1);
    chk8("w1_wr_addr", wr_addr_log[w0[5:0]], 8'h6B);
    chk8("w1_wr_data", wr_data_log[w0[5:0]], 8'h00);
    chk1("w1_busy_stop", BUSY, 1'b0);
    chk8("w1_ptr", REG_ADDR, 8'h6C);

    // pointer write, repeated start, 14-byte burst read
    r0 = rd_cnt; n0 = nack_cnt; w0 = wr_cnt;
    start_c();
    wbyte(8'hD0, a); chk1("b_ack_addr", a, 1'b1);
    wbyte(8'h3B, a); chk1("b_ack_ptr", a, 1'b1);
    start_c();
    wbyte(8'hD1, a); chk1("b_ack_raddr", a, 1'b1);
    for (int i = 0; i < 14; i++) begin
      rbyte(i < 13, d);
      chk8($sformatf("b_byte%0d", i), d, 8'(8'h3B + i));
    end
    chk1("b_busy_nack", BUSY, 1'b0);
    stop_c();
    chki("b_read_en", rd_cnt - r0, 14);
    chki("b_nack", nack_cnt - n0, 1);
    chki("b_no_write", wr_cnt - w0, 0);
    chk8("b_ptr", REG_ADDR, 8'h49);

    // foreign address is ignored
    w0 = wr_cnt; d0 = dir_cnt;
    start_c();
    wbyte(8'hD2, a); chk1("x_ack_addr", a, 1'b0);
    chk1("x_busy", BUSY, 1'b0);
    wbyte(8'h10, a); chk1("x_ack_b1", a, 1'b0);
    wbyte(8'h55, a); chk1("x_ack_b2", a, 1'b0);
    stop_c();
    chki("x_dir_cycles", dir_cnt - d0, 0);
    chki("x_no_write", wr_cnt - w0, 0);
    chk8("x_ptr", REG_ADDR, 8'h49);

    // pointer wrap 0xFF -> 0x00
    w0 = wr_cnt;
    start_c();
    wbyte(8'hD0, a);
    wbyte(8'hFF, a);
    wbyte(8'hAA, a); chk1("wrap_ack1", a, 1'b1);
    wbyte(8'hBB, a); chk1("wrap_ack2", a, 1'b1);
    stop_c();
    chki("wrap_count", wr_cnt - w0, 2);
    chk8("wrap_addr0", wr_addr_log[w0[5:0]], 8'hFF);
    chk8("wrap_data0", wr_data_log[w0[5:0]], 8'hAA);
    chk8("wrap_addr1", wr_addr_log[6'(w0 + 1)], 8'h00);
    chk8("wrap_data1", wr_data_log[6'(w0 + 1)], 8'hBB);
    chk8("wrap_ptr", REG_ADDR, 8'h01);

    // truncated data byte, then a full write
    w0 = wr_cnt;
    start_c();
    wbyte(8'hD0, a);
    wbyte(8'h10, a);
    sbit(1'b1, a); sbit(1'b0, a); sbit(1'b1, a); sbit(1'b1, a);
    stop_c();
    chki("t_no_write", wr_cnt - w0, 0);
    chk8("t_ptr", REG_ADDR, 8'h10);
    chk1("t_idle", dut.state == IDLE, 1'b1);
    chk1("t_busy", BUSY, 1'b0);
    start_c();
    wbyte(8'hD0, a);
    wbyte(8'h20, a);
    wbyte(8'h5A, a); chk1("t2_ack", a, 1'b1);
    stop_c();
    chki("t2_count", wr_cnt - w0, 1);
    chk8("t2_addr", wr_addr_log[w0[5:0]], 8'h20);
    chk8("t2_data", wr_data_log[w0[5:0]], 8'h5A);

    // reset while driving a '0' read bit
    start_c();
    wbyte(8'hD0, a);
    wbyte(8'h05, a);
    start_c();
    wbyte(8'hD1, a); chk1("r_ack", a, 1'b1);
    chk1("r_driving", SDA_DIR, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    #1 chk1("r_dir_same", SDA_DIR, 1'b0);
    @(posedge CLK);
    #1;
    chk1("r_dir", SDA_DIR, 1'b0);
    chk8("r_addr", REG_ADDR, 8'h00);
    chk1("r_busy", BUSY, 1'b0);
    chk1("r_ren", READ_EN, 1'b0);
    chk1("r_wen", WRITE_EN, 1'b0);
    chk8("r_wdata", WRITE_DATA, 8'h00);
    chk1("r_nack", NACK_SEEN, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    stop_c();
    start_c();
    wbyte(8'hD0, a); chk1("r2_ack", a, 1'b1);
    wbyte(8'h33, a);
    stop_c();
    chk8("r2_ptr", REG_ADDR, 8'h33);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
